uart_controller: RTL and testbench
==================================

# uart_controller

Buffering controller between a byte-level UART receiver/transmitter pair and the core's byte stream interfaces. Received bytes go into an RX FIFO that the core drains through a request/acknowledge handshake. Bytes from the core go into a TX FIFO that is fed to the transmitter whenever it is idle. The block also generates the sub-block resets and flags dropped received bytes.

## Interface

Parameters:
- `BUF_BITS`, default 4: log2 of FIFO depth. Each FIFO has 2^BUF_BITS slots and holds at most 2^BUF_BITS − 1 bytes (one slot always empty).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `recv_reset` out 1: active-high reset to the UART receiver.
- `recv_data` in 8: received byte.
- `recv_ok` in 1: `recv_data` valid this cycle (one byte per high cycle).
- `trans_reset` out 1: active-high reset to the UART transmitter.
- `trans_data` out 8: byte to transmit.
- `trans_ok` out 1: one-cycle start strobe for the transmitter.
- `trans_busy` in 1: transmitter is sending.
- `uart_in_data` in 8: byte from the core to send.
- `uart_in_valid` in 1: core requests to enqueue `uart_in_data`.
- `uart_in_ready` out 1: one-cycle acknowledge that `uart_in_data` was enqueued.
- `uart_out_valid` in 1: core requests a received byte.
- `uart_out_data` out 8: delivered received byte.
- `uart_out_ready` out 1: one-cycle strobe; `uart_out_data` is valid.
- `in_buffer_length` out BUF_BITS: TX FIFO occupancy.
- `lost` out 1: one-cycle pulse when a received byte was dropped.

## Operation

Reset:
- While `reset` is low, all registers clear and both FIFOs empty.
- `recv_reset` and `trans_reset` are set high asynchronously. They clear on the first rising edge after release.
- All other outputs are 0.

RX path:
- Each cycle `recv_ok`=1 pushes `recv_data`.
- If the RX FIFO is full at the start of that cycle, the byte is dropped and `lost` pulses on the next cycle.
- A pop in the same cycle does not free a slot for that cycle's push.

RX delivery FSM (OUT_IDLE, OUT_ACK):
- OUT_IDLE, with `uart_out_valid`=1 and RX not empty:
  - register `uart_out_data` = head;
  - `uart_out_ready` = 1;
  - pop;
  - go to OUT_ACK.
- OUT_ACK: `uart_out_ready` = 0 for one cycle, then return to OUT_IDLE.
- Result: at most one byte per two cycles. `uart_out_data` holds its value until the next delivery.

TX intake FSM (IN_IDLE, IN_ACK):
- IN_IDLE, with `uart_in_valid`=1 and TX not full:
  - push `uart_in_data`;
  - `uart_in_ready` = 1 for one cycle;
  - go to IN_ACK.
- IN_ACK: `uart_in_ready` = 0 for one cycle, then IN_IDLE.
- When the TX FIFO is full, the request is held without acknowledge. Nothing is dropped.
- The core must drop `uart_in_valid` or change data after seeing `uart_in_ready`.

TX drain FSM (TX_IDLE, TX_WAIT):
- TX_IDLE, with `trans_busy`=0 and TX not empty:
  - register `trans_data` = head;
  - `trans_ok` = 1 for one cycle;
  - pop;
  - go to TX_WAIT.
- TX_WAIT: one cycle, ignoring `trans_busy`, then TX_IDLE.
- The transmitter must raise `trans_busy` within one cycle of `trans_ok`.

FIFO rules:
- Pointers are BUF_BITS wide and wrap modulo 2^BUF_BITS.
- empty = (wr == rd); full = (wr + 1 == rd).
- Push and pop in the same cycle are both performed.
- `in_buffer_length` = wr − rd (mod 2^BUF_BITS).

## Timing

- Every handshake output is registered: it responds on the edge after the input is sampled.
- First `uart_out_ready` appears 1 cycle after `uart_out_valid` rises, given a non-empty FIFO.
- A byte pushed by `recv_ok` at edge k is deliverable from edge k+1.
- Back-to-back deliveries occur on alternate cycles.
- `trans_ok` strobes are separated by at least 2 cycles.
- Asserting `reset` mid-transfer aborts everything: FIFOs flush and the sub-blocks are reset.

## Test plan

- Reset: hold `reset` low for 5 cycles → `recv_reset` = `trans_reset` = 1, all other outputs 0. Release → both resets are 0 after one edge.
- RX basic:
  - Stimulus: `recv_ok` pulses with 0xB3, 0x5F, gap, 0xAA; then `uart_out_valid` = 1.
  - Response: ready = 1 with 0xB3, then 0, then 1 with 0x5F, then 0.
  - Drop valid, push 0x0F, re-request → 0xAA then 0x0F, then ready stays 0.
- RX overflow (BUF_BITS = 3):
  - Stimulus: 4 × 0xB3 then 8 × 0x4C on consecutive cycles.
  - Response: `lost` pulses 5 times. Reads return 4 × 0xB3 and 3 × 0x4C, each 2 cycles apart, then ready = 0.
- TX path:
  - Stimulus: push 0x5A, then 0x3C via `uart_in_valid`, with `trans_busy` = 0.
  - Response: `uart_in_ready` pulses once per byte; `trans_ok` pulses with `trans_data` = 0x5A.
  - Hold `trans_busy` = 1 → 0x3C is held, `in_buffer_length` = 1. Release → 0x3C is sent.
- TX full (BUF_BITS = 3): 7 bytes with `trans_busy` = 1 → `in_buffer_length` = 7. The 8th request gets no `uart_in_ready` until one byte drains.
- Simultaneous events: `recv_ok` in the same cycle as an RX delivery pop, and `uart_in_valid` in the same cycle as a `trans_ok` pop → occupancy unchanged, no data loss or reorder.

Source files
------------

// File: rtl/uart_controller.sv
// uart_controller
// Buffering glue between a byte-level UART receiver/transmitter pair and the
// core's byte stream handshakes.
//   clk, reset        : single clock; asynchronous active-low reset
//   recv_reset        : active-high reset to the receiver (held through reset)
//   recv_data/recv_ok : received byte and its one-cycle valid
//   trans_reset       : active-high reset to the transmitter (held through reset)
//   trans_data/trans_ok : byte to send and its one-cycle start strobe
//   trans_busy        : transmitter is sending
//   uart_in_*         : core -> TX FIFO request/acknowledge
//   uart_out_*        : RX FIFO -> core request/strobe
//   in_buffer_length  : TX FIFO occupancy
//   lost              : one-cycle pulse for each received byte dropped on overflow
module uart_controller #(
  parameter int BUF_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                recv_reset,
  input  logic [7:0]          recv_data,
  input  logic                recv_ok,
  output logic                trans_reset,
  output logic [7:0]          trans_data,
  output logic                trans_ok,
  input  logic                trans_busy,
  input  logic [7:0]          uart_in_data,
  input  logic                uart_in_valid,
  output logic                uart_in_ready,
  input  logic                uart_out_valid,
  output logic [7:0]          uart_out_data,
  output logic                uart_out_ready,
  output logic [BUF_BITS-1:0] in_buffer_length,
  output logic                lost
);

  localparam int DEPTH = 1 << BUF_BITS;
  localparam logic [BUF_BITS-1:0] PTR_ONE = BUF_BITS'(1);

  typedef enum logic {OUT_IDLE, OUT_ACK} out_state_t;
  typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  logic                recv_reset_q, recv_reset_d;
  logic                trans_reset_q, trans_reset_d;

  logic [7:0]          rx_mem_q [DEPTH];
  logic [7:0]          rx_mem_d [DEPTH];
  logic [BUF_BITS-1:0] rx_wr_q, rx_wr_d;
  logic [BUF_BITS-1:0] rx_rd_q, rx_rd_d;
  logic                lost_q, lost_d;
  out_state_t          out_state_q, out_state_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_ready_q, out_ready_d;

  logic [7:0]          tx_mem_q [DEPTH];
  logic [7:0]          tx_mem_d [DEPTH];
  logic [BUF_BITS-1:0] tx_wr_q, tx_wr_d;
  logic [BUF_BITS-1:0] tx_rd_q, tx_rd_d;
  in_state_t           in_state_q, in_state_d;
  logic                in_ready_q, in_ready_d;
  tx_state_t           tx_state_q, tx_state_d;
  logic [7:0]          trans_data_q, trans_data_d;
  logic                trans_ok_q, trans_ok_d;

  logic rx_empty, rx_full, tx_empty, tx_full;

  // One slot is always left unused so full and empty are distinguishable
  // from the pointers alone.
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = ((rx_wr_q + PTR_ONE) == rx_rd_q);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = ((tx_wr_q + PTR_ONE) == tx_rd_q);

  // Sub-block resets are forced high by the async reset and drop on the
  // first clock edge after release.
  always_comb begin
    recv_reset_d  = 1'b0;
    trans_reset_d = 1'b0;
  end

  // RX push: fullness is judged from the registered pointers, so a pop on the
  // same edge never makes room for this cycle's byte.
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    lost_d   = 1'b0;
    if (recv_ok) begin
      if (rx_full) begin
        lost_d = 1'b1;
      end else begin
        rx_mem_d[rx_wr_q] = recv_data;
        rx_wr_d           = rx_wr_q + PTR_ONE;
      end
    end
  end

  // RX delivery: one byte per request, then a mandatory idle cycle so the
  // core sees a clean one-cycle strobe per byte.
  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    out_ready_d = 1'b0;
    rx_rd_d     = rx_rd_q;
    case (out_state_q)
      OUT_IDLE: begin
        if (uart_out_valid && !rx_empty) begin
          out_data_d  = rx_mem_q[rx_rd_q];
          out_ready_d = 1'b1;
          rx_rd_d     = rx_rd_q + PTR_ONE;
          out_state_d = OUT_ACK;
        end
      end
      OUT_ACK:  out_state_d = OUT_IDLE;
      default:  out_state_d = OUT_IDLE;
    endcase
  end

  // TX intake: a request against a full FIFO simply waits; nothing is dropped.
  always_comb begin
    in_state_d = in_state_q;
    in_ready_d = 1'b0;
    tx_mem_d   = tx_mem_q;
    tx_wr_d    = tx_wr_q;
    case (in_state_q)
      IN_IDLE: begin
        if (uart_in_valid && !tx_full) begin
          tx_mem_d[tx_wr_q] = uart_in_data;
          tx_wr_d           = tx_wr_q + PTR_ONE;
          in_ready_d        = 1'b1;
          in_state_d        = IN_ACK;
        end
      end
      IN_ACK:  in_state_d = IN_IDLE;
      default: in_state_d = IN_IDLE;
    endcase
  end

  // TX drain: the wait state covers the cycle before the transmitter has
  // had a chance to raise trans_busy.
  always_comb begin
    tx_state_d   = tx_state_q;
    trans_data_d = trans_data_q;
    trans_ok_d   = 1'b0;
    tx_rd_d      = tx_rd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!trans_busy && !tx_empty) begin
          trans_data_d = tx_mem_q[tx_rd_q];
          trans_ok_d   = 1'b1;
          tx_rd_d      = tx_rd_q + PTR_ONE;
          tx_state_d   = TX_WAIT;
        end
      end
      TX_WAIT: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_reset_q  <= 1'b1;
      trans_reset_q <= 1'b1;
      rx_mem_q      <= '{default: '0};
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      lost_q        <= 1'b0;
      out_state_q   <= OUT_IDLE;
      out_data_q    <= '0;
      out_ready_q   <= 1'b0;
      tx_mem_q      <= '{default: '0};
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      in_state_q    <= IN_IDLE;
      in_ready_q    <= 1'b0;
      tx_state_q    <= TX_IDLE;
      trans_data_q  <= '0;
      trans_ok_q    <= 1'b0;
    end else begin
      recv_reset_q  <= recv_reset_d;
      trans_reset_q <= trans_reset_d;
      rx_mem_q      <= rx_mem_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      lost_q        <= lost_d;
      out_state_q   <= out_state_d;
      out_data_q    <= out_data_d;
      out_ready_q   <= out_ready_d;
      tx_mem_q      <= tx_mem_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      in_state_q    <= in_state_d;
      in_ready_q    <= in_ready_d;
      tx_state_q    <= tx_state_d;
      trans_data_q  <= trans_data_d;
      trans_ok_q    <= trans_ok_d;
    end
  end

  assign recv_reset       = recv_reset_q;
  assign trans_reset      = trans_reset_q;
  assign lost             = lost_q;
  assign uart_out_data    = out_data_q;
  assign uart_out_ready   = out_ready_q;
  assign uart_in_ready    = in_ready_q;
  assign trans_data       = trans_data_q;
  assign trans_ok         = trans_ok_q;
  assign in_buffer_length = tx_wr_q - tx_rd_q;

endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller
// Directed bench for uart_controller with 8-slot FIFOs. Expected RX and TX
// bytes are queued when stimulus is driven and compared by a monitor when the
// DUT strobes them out.
module tb_uart_controller;

  localparam int BB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          recv_reset;
  logic [7:0]    recv_data;
  logic          recv_ok;
  logic          trans_reset;
  logic [7:0]    trans_data;
  logic          trans_ok;
  logic          trans_busy;
  logic [7:0]    uart_in_data;
  logic          uart_in_valid;
  logic          uart_in_ready;
  logic          uart_out_valid;
  logic [7:0]    uart_out_data;
  logic          uart_out_ready;
  logic [BB-1:0] in_buffer_length;
  logic          lost;

  int checks = 0;
  int errors = 0;
  int lost_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic prev_out_ready = 1'b0;
  logic prev_trans_ok = 1'b0;

  always #5 clk = ~clk;

  uart_controller #(.BUF_BITS(BB)) dut (
    .clk              (clk),
    .reset            (reset),
    .recv_reset       (recv_reset),
    .recv_data        (recv_data),
    .recv_ok          (recv_ok),
    .trans_reset      (trans_reset),
    .trans_data       (trans_data),
    .trans_ok         (trans_ok),
    .trans_busy       (trans_busy),
    .uart_in_data     (uart_in_data),
    .uart_in_valid    (uart_in_valid),
    .uart_in_ready    (uart_in_ready),
    .uart_out_valid   (uart_out_valid),
    .uart_out_data    (uart_out_data),
    .uart_out_ready   (uart_out_ready),
    .in_buffer_length (in_buffer_length),
    .lost             (lost)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one received byte for one cycle; kept bytes are expected back in order.
  task automatic rx_push(input logic [7:0] b, input bit keep);
    recv_data = b;
    recv_ok   = 1'b1;
    if (keep) rx_q.push_back(b);
    next_cycle();
    recv_ok = 1'b0;
  endtask

  // Offer one byte to the TX intake and wait (bounded) for its acknowledge.
  task automatic tx_send(input logic [7:0] b);
    bit got;
    got           = 1'b0;
    uart_in_data  = b;
    uart_in_valid = 1'b1;
    tx_q.push_back(b);
    for (int i = 0; i < 20 && !got; i++) begin
      next_cycle();
      if (uart_in_ready) got = 1'b1;
    end
    check_output("tx_ack_seen", got, 1);
    uart_in_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (uart_out_ready) begin
        check_output("rx_q_nonempty", (rx_q.size() != 0), 1);
        if (rx_q.size() != 0) check_output("rx_data", uart_out_data, rx_q.pop_front());
        check_output("rx_spacing", prev_out_ready, 0);
      end
      if (trans_ok) begin
        check_output("tx_q_nonempty", (tx_q.size() != 0), 1);
        if (tx_q.size() != 0) check_output("tx_data", trans_data, tx_q.pop_front());
        check_output("tx_spacing", prev_trans_ok, 0);
      end
      if (lost) lost_cnt++;
    end
    prev_out_ready = uart_out_ready;
    prev_trans_ok  = trans_ok;
  end

  initial begin
    int lost_base;
    bit seen;

    reset          = 1'b0;
    recv_data      = '0;
    recv_ok        = 1'b0;
    trans_busy     = 1'b0;
    uart_in_data   = '0;
    uart_in_valid  = 1'b0;
    uart_out_valid = 1'b0;

    // Reset held for five cycles.
    repeat (5) next_cycle();
    check_output("rst_recv_reset", recv_reset, 1);
    check_output("rst_trans_reset", trans_reset, 1);
    check_output("rst_outputs", {9'd0, uart_out_ready, trans_ok, uart_in_ready, lost,
                                 in_buffer_length, uart_out_data, trans_data}, 0);
    reset = 1'b1;
    next_cycle();
    check_output("rel_recv_reset", recv_reset, 0);
    check_output("rel_trans_reset", trans_reset, 0);

    // RX basic.
    $display("[TB] rx basic");
    rx_push(8'hB3, 1);
    rx_push(8'h5F, 1);
    next_cycle();
    rx_push(8'hAA, 1);
    uart_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check_output("rxb_ready_seq", uart_out_ready, (i % 2 == 0));
    end
    uart_out_valid = 1'b0;
    next_cycle();
    check_output("rxb_pending", rx_q.size(), 1);
    rx_push(8'h0F, 1);
    uart_out_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      check_output("rxb_ready_seq2", uart_out_ready, (i == 0 || i == 2));
    end
    uart_out_valid = 1'b0;
    check_output("rxb_drained", rx_q.size(), 0);

    // RX overflow: 7 slots usable, the last 5 bytes are dropped.
    $display("[TB] rx overflow");
    lost_base = lost_cnt;
    for (int i = 0; i < 12; i++) rx_push((i < 4) ? 8'hB3 : 8'h4C, (i < 7));
    next_cycle();
    next_cycle();
    check_output("ovf_lost_count", lost_cnt - lost_base, 5);
    uart_out_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      check_output("ovf_ready_seq", uart_out_ready, (i < 14) && (i % 2 == 0));
    end
    uart_out_valid = 1'b0;
    check_output("ovf_drained", rx_q.size(), 0);

    // RX push in the same cycle as a delivery pop.
    $display("[TB] rx simultaneous");
    rx_push(8'h11, 1);
    rx_push(8'h22, 1);
    recv_data      = 8'h33;
    recv_ok        = 1'b1;
    uart_out_valid = 1'b1;
    rx_q.push_back(8'h33);
    next_cycle();
    recv_ok = 1'b0;
    check_output("sim_rx_ready", uart_out_ready, 1);
    for (int i = 0; i < 12 && rx_q.size() != 0; i++) next_cycle();
    next_cycle();
    uart_out_valid = 1'b0;
    check_output("sim_rx_drained", rx_q.size(), 0);
    check_output("sim_rx_no_loss", lost_cnt, 5);

    // TX path.
    $display("[TB] tx path");
    uart_in_data  = 8'h5A;
    uart_in_valid = 1'b1;
    tx_q.push_back(8'h5A);
    next_cycle();
    check_output("tx_ack_5a", uart_in_ready, 1);
    uart_in_data = 8'h3C;
    tx_q.push_back(8'h3C);
    next_cycle();
    check_output("tx_ack_gap", uart_in_ready, 0);
    check_output("tx_ok_5a", trans_ok, 1);
    trans_busy = 1'b1;
    next_cycle();
    check_output("tx_ack_3c", uart_in_ready, 1);
    uart_in_valid = 1'b0;
    next_cycle();
    check_output("tx_held_len", in_buffer_length, 1);
    next_cycle();
    check_output("tx_held_len2", in_buffer_length, 1);
    check_output("tx_held_ok", trans_ok, 0);
    trans_busy = 1'b0;
    next_cycle();
    check_output("tx_ok_3c", trans_ok, 1);
    check_output("tx_len_empty", in_buffer_length, 0);
    next_cycle();

    // TX full: 7 bytes fit, the 8th waits for a drain.
    $display("[TB] tx full");
    trans_busy = 1'b1;
    for (int i = 0; i < 7; i++) tx_send(8'h10 + 8'(i));
    next_cycle();
    check_output("txf_len7", in_buffer_length, 7);
    uart_in_data  = 8'h17;
    uart_in_valid = 1'b1;
    tx_q.push_back(8'h17);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (uart_in_ready) seen = 1'b1;
    end
    check_output("txf_no_ack", seen, 0);
    check_output("txf_len_still7", in_buffer_length, 7);
    trans_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      next_cycle();
      if (uart_in_ready) seen = 1'b1;
    end
    check_output("txf_ack_after_drain", seen, 1);
    uart_in_valid = 1'b0;
    for (int i = 0; i < 60 && tx_q.size() != 0; i++) next_cycle();
    next_cycle();
    check_output("txf_drained", tx_q.size(), 0);
    check_output("txf_len0", in_buffer_length, 0);

    // TX push in the same cycle as a drain pop.
    $display("[TB] tx simultaneous");
    trans_busy = 1'b1;
    tx_send(8'hA1);
    tx_send(8'hA2);
    next_cycle();
    next_cycle();
    check_output("sim_tx_len_before", in_buffer_length, 2);
    uart_in_data  = 8'hA3;
    uart_in_valid = 1'b1;
    trans_busy    = 1'b0;
    tx_q.push_back(8'hA3);
    next_cycle();
    uart_in_valid = 1'b0;
    check_output("sim_tx_ack", uart_in_ready, 1);
    check_output("sim_tx_ok", trans_ok, 1);
    check_output("sim_tx_len_after", in_buffer_length, 2);
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) next_cycle();
    next_cycle();
    check_output("sim_tx_drained", tx_q.size(), 0);
    check_output("sim_tx_len0", in_buffer_length, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
